alu_operand_stage: RTL

//   ID->EX pipeline stage feeding the 16-bit ALU (ADD/SUB/SLT/SLTI/...).

---
 rtl/alu_operand_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID->EX stage in front of the 16-bit ALU.
// Decodes the instruction word, builds operands A/B (sign-extended imm6 for
// I-type), and holds them in a two-entry skid buffer with valid/ready on both
// sides and a synchronous flush for branch redirects.
// Optional feature: define ALU_OPERAND_FWD_EN to let a same-cycle writeback
// (wb_valid/wb_dest/wb_data) override the register-file read at accept time.

// Combinational operand builder: one decoded instruction -> one buffer entry.
module alu_operand_build #(
    parameter int W      = 16,
    parameter int IMM_W  = 6,
    parameter int REG_AW = 3
) (
    input  logic [15:0]       instr,
    input  logic [W-1:0]      rs_data,
    input  logic [W-1:0]      rt_data,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [W-1:0]      wb_data,
    output logic [W-1:0]      a,
    output logic [W-1:0]      b,
    output logic [3:0]        op,
    output logic [REG_AW-1:0] dest
);
    logic              itype;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [IMM_W-1:0]  imm;
    logic [W-1:0]      imm_sext;
    logic [W-1:0]      rs_val;
    logic [W-1:0]      rt_val;

    // Fixed 16-bit instruction layout: [15:12] op, [11:9] rs, [8:6] rt, [5:0] imm6
    assign op       = instr[15:12];
    assign itype    = instr[15];
    assign rs       = instr[9 +: REG_AW];
    assign rt       = instr[6 +: REG_AW];
    assign imm      = instr[IMM_W-1:0];
    assign imm_sext = {{(W-IMM_W){imm[IMM_W-1]}}, imm};

`ifdef ALU_OPERAND_FWD_EN
    // A writeback landing this cycle is newer than the regfile read port.
    assign rs_val = (wb_valid && (wb_dest == rs)) ? wb_data : rs_data;
    assign rt_val = (wb_valid && (wb_dest == rt)) ? wb_data : rt_data;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_dest, wb_data};
    assign rs_val    = rs_data;
    assign rt_val    = rt_data;
`endif

    // r0 is hardwired zero; this also keeps a stray writeback to r0 from leaking in.
    assign a    = (rs == '0) ? '0 : rs_val;
    assign b    = itype ? imm_sext : ((rt == '0) ? '0 : rt_val);
    // I-type writes rt; R-type carries its destination in imm6[5:3].
    assign dest = itype ? rt : imm[5:3];
endmodule

module alu_operand_stage #(
    parameter int W      = 16,
    parameter int IMM_W  = 6,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic [W-1:0]      rs_data,
    input  logic [W-1:0]      rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      A,
    output logic [W-1:0]      B,
    output logic [3:0]        alu_op,
    output logic [REG_AW-1:0] dest,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [W-1:0]      wb_data
);
    typedef struct packed {
        logic [W-1:0]      a;
        logic [W-1:0]      b;
        logic [3:0]        op;
        logic [REG_AW-1:0] dest;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t state;
    entry_t m;          // main entry, drives the ALU
    entry_t s;          // skid entry, only valid in ST_TWO
    entry_t incoming;
    logic   accept;
    logic   issue;

    alu_operand_build #(.W(W), .IMM_W(IMM_W), .REG_AW(REG_AW)) u_build (
        .instr    (instr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wb_valid (wb_valid),
        .wb_dest  (wb_dest),
        .wb_data  (wb_data),
        .a        (incoming.a),
        .b        (incoming.b),
        .op       (incoming.op),
        .dest     (incoming.dest)
    );

    assign accept    = in_valid && in_ready;
    assign issue     = out_valid && out_ready;
    assign out_valid = (state != ST_EMPTY);

    assign A      = m.a;
    assign B      = m.b;
    assign alu_op = m.op;
    assign dest   = m.dest;

    // Skid-buffer FSM; in_ready is registered alongside state so upstream
    // never sees a combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
            m        <= '0;
            s        <= '0;
        end else if (flush) begin
            // Entries are dropped by state alone; data regs keep stale values.
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m     <= incoming;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && issue) begin
                        m <= incoming;
                    end else if (accept) begin
                        s        <= incoming;
                        state    <= ST_TWO;
                        in_ready <= 1'b0;
                    end else if (issue) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (issue) begin
                        m        <= s;
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Registered in_ready must always mirror the state encoding.
    a_ready_tracks_state: assert property (@(posedge clk) disable iff (rst)
        in_ready == (state != ST_TWO));

    // A stalled output must not change under the consumer.
    a_hold_when_stalled: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable(A) && $stable(B) && $stable(alu_op) && $stable(dest)));
endmodule
